board_compact: RTL and testbench

Row-compaction engine that runs after line clearing in the tetris board pipeline. The board arrives with every completed line already overwritten with EMPTY. This block drops all non-empty rows toward the bottom, preserving their order, and refills the top with EMPTY rows. It holds the compacted board in its own register and pulses `done` when that board is valid for the next board-state update.

---
 rtl/board_compact.sv | 121 ++++++++++++
 tb/tb_board_compact.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/board_compact.sv
// Row-compaction engine: drops non-empty rows to the bottom of the board,
// preserving their order, then refills the top with EMPTY rows.
module board_compact #(
  parameter int unsigned x_size  = 10,
  parameter int unsigned y_size  = 20,
  parameter int unsigned color_w = 3
) (
  input  logic                                     Clk,
  input  logic                                     Reset,
  input  logic                                     start,
  input  logic [y_size-1:0][x_size-1:0][color_w-1:0] board_in,
  output logic [y_size-1:0][x_size-1:0][color_w-1:0] board_out,
  output logic                                     busy,
  output logic                                     done,
  output logic [4:0]                               empty_rows
);

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_e;
  typedef logic [x_size-1:0][color_w-1:0] row_t;

  localparam logic [color_w-1:0] EMPTY    = '0;
  localparam logic [4:0]         LAST_ROW = 5'(y_size - 1);

  state_e                                     state_q, state_d;
  logic [y_size-1:0][x_size-1:0][color_w-1:0] board_q, board_d;
  logic [4:0]                                 src_q, src_d;
  logic [4:0]                                 dst_q, dst_d;
  logic [4:0]                                 empty_q, empty_d;
  logic                                       busy_q, done_q;

  function automatic logic row_empty(input row_t row);
    logic all_empty;
    all_empty = 1'b1;
    for (int unsigned c = 0; c < x_size; c++) begin
      if (row[c] != EMPTY) begin
        all_empty = 1'b0;
      end else begin
        all_empty = all_empty;
      end
    end
    return all_empty;
  endfunction

  // Next-state: dst never drops below src, so the in-place row copy is safe.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    src_d   = src_q;
    dst_d   = dst_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          board_d = board_in;
          src_d   = LAST_ROW;
          dst_d   = LAST_ROW;
          empty_d = 5'd0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (row_empty(board_q[src_q])) begin
          empty_d = empty_q + 5'd1;
        end else begin
          board_d[dst_q] = board_q[src_q];
          dst_d          = dst_q - 5'd1;
        end
        src_d = src_q - 5'd1;
        if (src_q == 5'd0) begin
          state_d = (empty_d != 5'd0) ? FILL : DONE;
        end else begin
          state_d = SCAN;
        end
      end
      FILL: begin
        board_d[dst_q] = '0;
        dst_d          = dst_q - 5'd1;
        if (dst_q == 5'd0) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, board and status registers; busy/done are registered from next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      board_q <= '0;
      src_q   <= 5'd0;
      dst_q   <= 5'd0;
      empty_q <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      empty_q <= empty_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign board_out  = board_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign empty_rows = empty_q;

endmodule

// File: tb/tb_board_compact.sv
// Self-checking bench for board_compact: directed scenarios plus random boards
// checked against a queue-based compaction model.
module tb_board_compact;

  typedef logic [9:0][2:0]  row_t;
  typedef row_t [19:0]      board_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  board_t     board_in;
  board_t     board_out;
  logic       busy;
  logic       done;
  logic [4:0] empty_rows;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  board_compact dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .board_in   (board_in),
    .board_out  (board_out),
    .busy       (busy),
    .done       (done),
    .empty_rows (empty_rows)
  );

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: keep non-empty rows in top-to-bottom order, stack them at the bottom.
  function automatic board_t model(input board_t b, output int e);
    row_t   keep[$];
    board_t r;
    for (int i = 0; i < 20; i++) if (b[i] != '0) keep.push_back(b[i]);
    e = 20 - keep.size();
    r = '0;
    for (int i = 0; i < keep.size(); i++) r[e + i] = keep[i];
    return r;
  endfunction

  function automatic row_t tagged_row(input int r);
    row_t row;
    for (int c = 0; c < 10; c++) row[c] = 3'd5;
    row[0] = 3'((r % 7) + 1);
    row[1] = 3'((r / 7) + 1);
    return row;
  endfunction

  task automatic run_job(input board_t b, input int exp_lat, input string tag);
    board_t exp_b;
    board_t b_at_done;
    int     e;
    int     pulses   = 0;
    int     done_cyc = -1;
    logic [4:0] e_at_done = 5'bx;
    logic   busy_ok  = 1'b1;
    b_at_done = 'x;
    exp_b = model(b, e);
    @(negedge Clk);
    board_in = b;
    start    = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge Clk);
      if (done) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc  = k;
          b_at_done = board_out;
          e_at_done = empty_rows;
        end
      end
      if (k <= exp_lat && !busy) busy_ok = 1'b0;
      if (k == exp_lat + 1 && busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 640'(done_cyc), 640'(exp_lat));
    check({tag, "_pulses"},  640'(pulses),   640'd1);
    check({tag, "_busy"},    640'(busy_ok),  640'd1);
    check({tag, "_empty"},   640'(e_at_done), 640'(e));
    check({tag, "_board"},   640'(b_at_done), 640'(exp_b));
    check({tag, "_hold"},    640'(board_out), 640'(exp_b));
  endtask

  initial begin
    board_t b;
    int     pulses;
    int     e;
    Reset    = 1'b1;
    start    = 1'b0;
    board_in = '0;
    repeat (2) @(negedge Clk);
    check("reset_busy",  640'(busy), 640'd0);
    check("reset_done",  640'(done), 640'd0);
    check("reset_empty", 640'(empty_rows), 640'd0);
    check("reset_board", 640'(board_out), 640'd0);
    Reset = 1'b0;

    // Single clear: rows 17/18 patterns, everything else empty.
    b = '0;
    b[17] = tagged_row(3);
    b[18] = tagged_row(11);
    run_job(b, 39, "single");

    // Full board, no empty rows.
    for (int r = 0; r < 20; r++) b[r] = tagged_row(r);
    run_job(b, 21, "full");

    // Interleaved clears.
    for (int r = 0; r < 20; r++) b[r] = tagged_row(r);
    b[13] = '0; b[15] = '0; b[17] = '0; b[19] = '0;
    run_job(b, 25, "interleave");

    // All-empty board.
    run_job('0, 41, "allempty");

    // Start held high for cycles 0..30: one job only.
    b = '0;
    b[17] = tagged_row(6);
    b[18] = tagged_row(9);
    pulses = 0;
    @(negedge Clk);
    board_in = b;
    start    = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge Clk);
      if (k == 31) start = 1'b0;
      if (done) begin
        pulses++;
        check("held_done_cycle", 640'(k), 640'd39);
      end
    end
    check("held_pulses", 640'(pulses), 640'd1);

    // Reset mid-job in cycle 10, then a fresh job.
    for (int r = 0; r < 20; r++) b[r] = tagged_row(r);
    b[2] = '0;
    @(negedge Clk);
    board_in = b;
    start    = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("abort_busy",  640'(busy), 640'd0);
    check("abort_done",  640'(done), 640'd0);
    check("abort_empty", 640'(empty_rows), 640'd0);
    check("abort_board", 640'(board_out), 640'd0);
    @(negedge Clk);
    Reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (done) pulses++;
    end
    check("abort_nodone", 640'(pulses), 640'd0);
    check("abort_hold",   640'(board_out), 640'd0);
    run_job(b, 22, "after_abort");

    // Random boards against the reference model.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < 20; r++) begin
        if ($urandom_range(0, 2) == 0) begin
          b[r] = '0;
        end else begin
          for (int c = 0; c < 10; c++) b[r][c] = 3'($urandom_range(0, 7));
          b[r][$urandom_range(0, 9)] = 3'($urandom_range(1, 7));
        end
      end
      void'(model(b, e));
      run_job(b, 21 + e, $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
